// File: rtl/mul_pkg.sv
// Shared decode constants and FSM state type for the iterative multiplier.
// Imported by the multiplier top and its digit-step datapath.
package mul_pkg;

    localparam logic [6:0] OP_OP     = 7'b0110011;
    localparam logic [6:0] F7_MULDIV = 7'b0000001;

    localparam logic [2:0] F3_MUL    = 3'b000;
    localparam logic [2:0] F3_MULH   = 3'b001;
    localparam logic [2:0] F3_MULHSU = 3'b010;
    localparam logic [2:0] F3_MULHU  = 3'b011;

    typedef enum logic [1:0] {
        IDLE,
        ITER,
        FIX,
        DONE
    } state_t;

endpackage

// File: rtl/mul_digit_step.sv
// One radix-2^BPC shift-add step: acc_out = acc_in + (a_mag * digit) << (idx*BPC).
// Ports: a_mag, digit, idx (digit position), acc_in -> acc_out (2*XLEN wide).
module mul_digit_step
    import mul_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int BPC  = 4,
    parameter int IW   = 4
) (
    input  logic [XLEN-1:0]   a_mag,
    input  logic [BPC-1:0]    digit,
    input  logic [IW-1:0]     idx,
    input  logic [2*XLEN-1:0] acc_in,
    output logic [2*XLEN-1:0] acc_out
);

    localparam int SW = $clog2(2 * XLEN) + 1;

    logic [2*XLEN-1:0] partial;
    logic [SW-1:0]     sh;

    always_comb begin
        partial = {{XLEN{1'b0}}, a_mag} * {{(2*XLEN-BPC){1'b0}}, digit};
        sh      = SW'(idx) * SW'(BPC);
        acc_out = acc_in + (partial << sh);
    end

endmodule

// File: rtl/iterative_multiplier_unit.sv
// Multi-cycle RV32M/RV64M MUL/MULH/MULHSU/MULHU with start/busy/done handshake.
// Ports: clk, reset (async, active-low), start, kill, opcode/funct3/funct7,
// accuracy_level, bus_rs1, bus_rs2 -> mul_unit_busy, mul_done, mul_output.
module iterative_multiplier_unit
    import mul_pkg::*;
#(
    parameter int XLEN           = 32,
    parameter int BITS_PER_CYCLE = 4,
    parameter int APPROXIMATE    = 0,
    parameter int ACCURACY       = 0,
    parameter int FIXED_TRUNC    = 0
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic            kill,
    input  logic [6:0]      opcode,
    input  logic [2:0]      funct3,
    input  logic [6:0]      funct7,
    input  logic [7:0]      accuracy_level,
    input  logic [XLEN-1:0] bus_rs1,
    input  logic [XLEN-1:0] bus_rs2,
    output logic            mul_unit_busy,
    output logic            mul_done,
    output logic [XLEN-1:0] mul_output
);

    localparam int N  = XLEN / BITS_PER_CYCLE;
    localparam int IW = $clog2(N) + 1;

    state_t              state;
    logic [1:0]          op_q;
    logic                sign_a_q;
    logic                sign_b_q;
    logic [XLEN-1:0]     a_mag_q;
    logic [XLEN-1:0]     b_sh_q;
    logic [2*XLEN-1:0]   prod_q;
    logic [IW-1:0]       iter_q;

    logic                is_mul;
    logic                accept;
    logic                signed_a;
    logic                signed_b;
    logic                sgn_a;
    logic                sgn_b;
    logic [XLEN-1:0]     a_mag;
    logic [XLEN-1:0]     b_mag;
    logic [XLEN-1:0]     b_mask;
    logic [XLEN-1:0]     b_trunc;
    int                  k;
    logic [2*XLEN-1:0]   acc_next;
    logic [2*XLEN-1:0]   fixed;
    logic [XLEN-1:0]     result;

    assign is_mul = (opcode == OP_OP) && (funct7 == F7_MULDIV)
                  && (funct3[2] == 1'b0);
    assign accept = (state == IDLE) && start && !kill && is_mul;

    always_comb begin
        signed_a = 1'b0;
        signed_b = 1'b0;
        unique case (funct3)
            F3_MUL:    begin signed_a = 1'b1; signed_b = 1'b1; end
            F3_MULH:   begin signed_a = 1'b1; signed_b = 1'b1; end
            F3_MULHSU: begin signed_a = 1'b1; signed_b = 1'b0; end
            F3_MULHU:  begin signed_a = 1'b0; signed_b = 1'b0; end
            default:   begin signed_a = 1'b0; signed_b = 1'b0; end
        endcase
    end

    // Negating min_int yields 2^(XLEN-1), which is the correct unsigned magnitude.
    always_comb begin
        sgn_a = signed_a & bus_rs1[XLEN-1];
        sgn_b = signed_b & bus_rs2[XLEN-1];
        a_mag = sgn_a ? -bus_rs1 : bus_rs1;
        b_mag = sgn_b ? -bus_rs2 : bus_rs2;
    end

    // Approximation drops the low k bits of |b|; k >= XLEN clears it entirely.
    always_comb begin
        k = 0;
        if (APPROXIMATE != 0) begin
            k = (ACCURACY != 0) ? int'(accuracy_level) : FIXED_TRUNC;
        end
        for (int i = 0; i < XLEN; i++) begin
            b_mask[i] = (i >= k);
        end
        b_trunc = b_mag & b_mask;
    end

    mul_digit_step #(
        .XLEN (XLEN),
        .BPC  (BITS_PER_CYCLE),
        .IW   (IW)
    ) u_step (
        .a_mag   (a_mag_q),
        .digit   (b_sh_q[BITS_PER_CYCLE-1:0]),
        .idx     (iter_q),
        .acc_in  (prod_q),
        .acc_out (acc_next)
    );

    always_comb begin
        fixed  = (sign_a_q ^ sign_b_q) ? -prod_q : prod_q;
        result = (op_q == 2'b00) ? fixed[XLEN-1:0] : fixed[2*XLEN-1:XLEN];
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state         <= IDLE;
            op_q          <= '0;
            sign_a_q      <= 1'b0;
            sign_b_q      <= 1'b0;
            a_mag_q       <= '0;
            b_sh_q        <= '0;
            prod_q        <= '0;
            iter_q        <= '0;
            mul_unit_busy <= 1'b0;
            mul_done      <= 1'b0;
            mul_output    <= '0;
        end else begin
            mul_done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (accept) begin
                        state         <= ITER;
                        mul_unit_busy <= 1'b1;
                        op_q          <= funct3[1:0];
                        sign_a_q      <= sgn_a;
                        sign_b_q      <= sgn_b;
                        a_mag_q       <= a_mag;
                        b_sh_q        <= b_trunc;
                        prod_q        <= '0;
                        iter_q        <= '0;
                    end
                end
                ITER: begin
                    if (kill) begin
                        state         <= IDLE;
                        mul_unit_busy <= 1'b0;
                    end else begin
                        prod_q <= acc_next;
                        b_sh_q <= b_sh_q >> BITS_PER_CYCLE;
                        iter_q <= iter_q + IW'(1);
                        if (iter_q == IW'(N - 1)) begin
                            state <= FIX;
                        end
                    end
                end
                FIX: begin
                    state         <= kill ? IDLE : DONE;
                    mul_unit_busy <= 1'b0;
                    if (!kill) begin
                        mul_done   <= 1'b1;
                        mul_output <= result;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_iterative_multiplier_unit.sv
// Self-checking bench for iterative_multiplier_unit: exact BPC=4 instance
// plus an approximate BPC=1 instance, both checked against arithmetic models.
module tb_iterative_multiplier_unit;

    logic        clk;
    logic        rst0, start0, kill0;
    logic        rst1, start1, kill1;
    logic [6:0]  opcode, funct7;
    logic [2:0]  funct3;
    logic [7:0]  acc_lvl;
    logic [31:0] rs1, rs2;
    logic        busy0, done0, busy1, done1;
    logic [31:0] out0, out1;

    int n_cmp = 0;
    int n_bad = 0;

    iterative_multiplier_unit #(
        .XLEN(32), .BITS_PER_CYCLE(4), .APPROXIMATE(0),
        .ACCURACY(0), .FIXED_TRUNC(0)
    ) dut0 (
        .clk(clk), .reset(rst0), .start(start0), .kill(kill0),
        .opcode(opcode), .funct3(funct3), .funct7(funct7),
        .accuracy_level(acc_lvl), .bus_rs1(rs1), .bus_rs2(rs2),
        .mul_unit_busy(busy0), .mul_done(done0), .mul_output(out0)
    );

    iterative_multiplier_unit #(
        .XLEN(32), .BITS_PER_CYCLE(1), .APPROXIMATE(1),
        .ACCURACY(1), .FIXED_TRUNC(0)
    ) dut1 (
        .clk(clk), .reset(rst1), .start(start1), .kill(kill1),
        .opcode(opcode), .funct3(funct3), .funct7(funct7),
        .accuracy_level(acc_lvl), .bus_rs1(rs1), .bus_rs2(rs2),
        .mul_unit_busy(busy1), .mul_done(done1), .mul_output(out1)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] ref_exact(input logic [1:0] op,
                                              input logic [31:0] a,
                                              input logic [31:0] b);
        logic signed [65:0] x, y, p;
        x = (op == 2'd3) ? $signed({34'd0, a}) : $signed({{34{a[31]}}, a});
        y = (op[1] == 1'b1) ? $signed({34'd0, b}) : $signed({{34{b[31]}}, b});
        p = x * y;
        return (op == 2'd0) ? p[31:0] : p[63:32];
    endfunction

    function automatic logic [31:0] ref_approx(input logic [1:0] op,
                                               input logic [31:0] a,
                                               input logic [31:0] b,
                                               input int k);
        logic        sa, sb;
        logic [31:0] am, bm, m;
        logic [63:0] p;
        sa = (op != 2'd3) && a[31];
        sb = (op[1] == 1'b0) && b[31];
        am = sa ? (32'd0 - a) : a;
        bm = sb ? (32'd0 - b) : b;
        m  = '1;
        if (k >= 32) m = '0;
        else         m = m << k;
        bm = bm & m;
        p  = {32'd0, am} * {32'd0, bm};
        if (sa ^ sb) p = 64'd0 - p;
        return (op == 2'd0) ? p[31:0] : p[63:32];
    endfunction

    task automatic check(input string tag, input logic [63:0] obs,
                         input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic issue(input int w, input logic [6:0] f7,
                         input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] b, input logic kl);
        opcode = 7'b0110011;
        funct7 = f7;
        funct3 = f3;
        rs1    = a;
        rs2    = b;
        if (w == 0) begin start0 = 1'b1; kill0 = kl; end
        else        begin start1 = 1'b1; kill1 = kl; end
        @(posedge clk); #1;
        start0 = 1'b0; kill0 = 1'b0;
        start1 = 1'b0; kill1 = 1'b0;
    endtask

    task automatic watch(input int w, input int len, input int busy_last,
                         input int s1, input int s2, input int kill_at,
                         output int done_at, output bit ok);
        logic b, d;
        done_at = -1;
        ok = 1'b1;
        for (int c = 1; c <= len; c++) begin
            if (w == 0) begin
                start0 = (c == s1) || (c == s2);
                kill0  = (c == kill_at);
            end else begin
                start1 = (c == s1) || (c == s2);
                kill1  = (c == kill_at);
            end
            @(negedge clk);
            b = (w == 0) ? busy0 : busy1;
            d = (w == 0) ? done0 : done1;
            if (b !== (c <= busy_last)) ok = 1'b0;
            if (d === 1'b1) begin
                if (done_at < 0) done_at = c;
                else ok = 1'b0;
            end else if (d !== 1'b0) begin
                ok = 1'b0;
            end
            @(posedge clk); #1;
        end
        start0 = 1'b0; kill0 = 1'b0;
        start1 = 1'b0; kill1 = 1'b0;
    endtask

    task automatic full_op(input int w, input logic [2:0] f3,
                           input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] exp, input string tag);
        int n, d;
        bit ok;
        n = (w == 0) ? 8 : 32;
        issue(w, 7'b0000001, f3, a, b, 1'b0);
        watch(w, n + 2, n + 1, -1, -1, -1, d, ok);
        check({tag, ".done_cycle"}, 64'(d), 64'(n + 2));
        check({tag, ".busy"}, 64'(ok), 64'd1);
        check({tag, ".result"}, 64'((w == 0) ? out0 : out1), 64'(exp));
    endtask

    initial begin
        int d;
        bit ok;
        logic [1:0]  op;
        logic [31:0] a, b;
        int k;

        clk = 1'b0;
        rst0 = 1'b0; rst1 = 1'b0;
        start0 = 1'b0; kill0 = 1'b0;
        start1 = 1'b0; kill1 = 1'b0;
        opcode = '0; funct3 = '0; funct7 = '0;
        acc_lvl = '0; rs1 = '0; rs2 = '0;

        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset.busy0", 64'(busy0), 64'd0);
        check("reset.done0", 64'(done0), 64'd0);
        check("reset.out0", 64'(out0), 64'd0);
        check("reset.busy1", 64'(busy1), 64'd0);
        check("reset.out1", 64'(out1), 64'd0);
        @(posedge clk); #1;
        rst0 = 1'b1; rst1 = 1'b1;
        @(posedge clk); #1;

        // MUL 7 x -3 with extra starts at cycles 3 and 10 that must be ignored
        issue(0, 7'b0000001, 3'b000, 32'd7, 32'hFFFFFFFD, 1'b0);
        watch(0, 10, 9, 3, 10, -1, d, ok);
        check("mul_neg.done_cycle", 64'(d), 64'd10);
        check("mul_neg.busy", 64'(ok), 64'd1);
        check("mul_neg.result", 64'(out0), 64'hFFFFFFEB);

        // start in cycle 11 is accepted; done ten cycles later (cycle 21)
        issue(0, 7'b0000001, 3'b000, 32'h12345, 32'h10, 1'b0);
        watch(0, 10, 9, -1, -1, -1, d, ok);
        check("b2b.done_cycle", 64'(d), 64'd10);
        check("b2b.busy", 64'(ok), 64'd1);
        check("b2b.result", 64'(out0), 64'h123450);

        full_op(0, 3'b001, 32'h80000000, 32'h80000000, 32'h40000000, "mulh_min");
        full_op(0, 3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, "mulhu_max");
        full_op(0, 3'b010, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, "mulhsu_m1");
        full_op(0, 3'b000, 32'd0, 32'd0, 32'd0, "mul_zero");
        full_op(0, 3'b010, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, "mulhsu_again");

        // kill mid-ITER
        issue(0, 7'b0000001, 3'b000, 32'd3, 32'd5, 1'b0);
        watch(0, 12, 5, -1, -1, 5, d, ok);
        check("kill.no_done", 64'(d), 64'hFFFFFFFFFFFFFFFF);
        check("kill.busy", 64'(ok), 64'd1);
        check("kill.out_held", 64'(out0), 64'hFFFFFFFF);

        // kill coincident with start blocks acceptance
        issue(0, 7'b0000001, 3'b000, 32'd3, 32'd5, 1'b1);
        watch(0, 12, 0, -1, -1, -1, d, ok);
        check("killstart.no_done", 64'(d), 64'hFFFFFFFFFFFFFFFF);
        check("killstart.busy", 64'(ok), 64'd1);
        check("killstart.out_held", 64'(out0), 64'hFFFFFFFF);

        // non-M opcode (ADD) ignored
        issue(0, 7'b0000000, 3'b000, 32'd3, 32'd5, 1'b0);
        watch(0, 12, 0, -1, -1, -1, d, ok);
        check("add.no_done", 64'(d), 64'hFFFFFFFFFFFFFFFF);
        check("add.busy", 64'(ok), 64'd1);
        check("add.out_held", 64'(out0), 64'hFFFFFFFF);

        // reset asserted in cycle 4 of an operation
        issue(0, 7'b0000001, 3'b000, 32'd6, 32'd7, 1'b0);
        watch(0, 3, 3, -1, -1, -1, d, ok);
        check("pre_rst.busy", 64'(ok), 64'd1);
        rst0 = 1'b0;
        #1;
        check("midrst.busy", 64'(busy0), 64'd0);
        check("midrst.done", 64'(done0), 64'd0);
        check("midrst.out", 64'(out0), 64'd0);
        @(posedge clk); #1;
        rst0 = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 12; i++) begin
            op = 2'($urandom_range(0, 3));
            a = $urandom;
            b = $urandom;
            if (i == 0) a = 32'h80000000;
            if (i == 1) b = 32'h7FFFFFFF;
            full_op(0, {1'b0, op}, a, b, ref_exact(op, a, b), "rand_exact");
        end

        acc_lvl = 8'd4;
        full_op(1, 3'b000, 32'd10, 32'h1F, 32'hA0, "approx_k4");
        acc_lvl = 8'd0;
        full_op(1, 3'b000, 32'd10, 32'h1F, 32'h136, "approx_k0");
        full_op(1, 3'b000, 32'd7, 32'hFFFFFFFD, 32'hFFFFFFEB, "bpc1_mul_neg");

        for (int i = 0; i < 6; i++) begin
            op = 2'($urandom_range(0, 3));
            a = $urandom;
            b = $urandom;
            k = (i == 0) ? 40 : int'($urandom_range(0, 33));
            acc_lvl = 8'(k);
            full_op(1, {1'b0, op}, a, b, ref_approx(op, a, b, k), "rand_approx");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/iterative_multiplier_unit.md
Name: iterative_multiplier_unit

Overview:
- Multi-cycle, parametrised successor to the combinational multiplier unit in the phoeniX execute stage.
- Computes RV32M/RV64M MUL, MULH, MULHSU and MULHU with a radix-2^BITS_PER_CYCLE shift-add datapath.
- Exposes a start/busy/done handshake so the core stalls on `busy`.
- Supports optional approximate operation driven by accuracy_level from the CSRs.

Parameters:
- XLEN, 32, operand and result width; must be a multiple of BITS_PER_CYCLE.
- BITS_PER_CYCLE, 4, multiplier bits retired per iteration cycle (1, 2, 4 or 8).
- APPROXIMATE, 0, 1 enables operand truncation by accuracy_level.
- ACCURACY, 0, 1 means accuracy_level is honoured; 0 with APPROXIMATE=1 forces the fixed truncation FIXED_TRUNC.
- FIXED_TRUNC, 0, low bits truncated when APPROXIMATE=1 and ACCURACY=0.

Ports:
- clk  input  1  core clock, rising edge
- reset  input  1  asynchronous, active-low reset
- start  input  1  request pulse; sampled only in IDLE
- kill  input  1  pipeline flush; aborts the operation in flight
- opcode  input  7  instruction opcode
- funct3  input  3  instruction funct3
- funct7  input  7  instruction funct7
- accuracy_level  input  8  truncation amount k
- bus_rs1  input  XLEN  operand 1
- bus_rs2  input  XLEN  operand 2
- mul_unit_busy  output  1  high while an operation is in flight
- mul_done  output  1  one-cycle completion pulse
- mul_output  output  XLEN  result; held until the next accepted start

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE; mul_unit_busy=0; mul_done=0; mul_output=0; all internal registers=0.
- Accepted start: state=IDLE, start=1, kill=0, and {funct7,funct3,opcode} equal to 0000001_0xx_0110011. Any other opcode is ignored: no busy, mul_output unchanged.
- Acceptance latches:
  - op = funct3[1:0]
  - sign_a = signed op (MUL, MULH, MULHSU) AND rs1[XLEN-1]
  - sign_b = signed op (MUL, MULH) AND rs2[XLEN-1]
  - magnitudes |a| and |b| as XLEN-bit unsigned values, where |min_int| = 2^(XLEN-1)
- Approximation: when APPROXIMATE=1, the low k bits of |b| are zeroed. k=min(accuracy_level,XLEN) if ACCURACY=1, otherwise k=FIXED_TRUNC. APPROXIMATE=0 is always exact and accuracy_level is ignored.
- States:
  - IDLE -> ITER on accepted start.
  - ITER runs N=XLEN/BITS_PER_CYCLE cycles. Each cycle: product(2*XLEN) += (|a| * b_digit) << (iter*BITS_PER_CYCLE). The iteration counter has ceil(log2 N)+1 bits. -> FIX after N cycles.
  - FIX, 1 cycle: two's-complement negate the 2*XLEN product if sign_a XOR sign_b. Select the low XLEN bits for MUL, the high XLEN bits otherwise. -> DONE.
  - DONE, 1 cycle: register mul_output, pulse mul_done=1. -> IDLE.
- Timing: with start accepted at edge 0, mul_unit_busy is 1 during cycles 1..N+1 (ITER and FIX). mul_done=1 in cycle N+2, when busy=0. Total latency is N+2 cycles; XLEN=32, BPC=4 gives 10.
- Back-to-back: start while busy is ignored. A new start is accepted in the DONE cycle's following IDLE cycle at the earliest. A start coinciding with mul_done is not accepted.
- kill in ITER or FIX: next state IDLE, busy=0, no mul_done, mul_output unchanged. kill coincident with start in IDLE blocks acceptance. kill in DONE has no effect.
- Reset mid-operation: immediate return to reset values; no done pulse.
- Corner cases: overflow of the low-half result wraps (mod 2^XLEN). 0 operands still take the full latency (no early termination).

Decomposition:
- Shared package mul_pkg:
  - opcode constant OP_OP=0110011 and funct7 constant F7_MULDIV=0000001
  - funct3 codes MUL=000, MULH=001, MULHSU=010, MULHU=011
  - state enum IDLE/ITER/FIX/DONE
- Sub-module mul_digit_step (combinational): takes |a|, one BITS_PER_CYCLE digit of b, the shift index and the accumulator; returns the next accumulator. It is reusable by a future divider/MAC.

Test Plan:
- XLEN=32, BPC=4: MUL rs1=7, rs2=0xFFFFFFFD (-3) -> mul_done at cycle 10, mul_output=0xFFFFFFEB, busy high cycles 1..9.
- MULH 0x80000000 x 0x80000000 -> 0x40000000. MULHU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE. MULHSU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFF.
- start pulsed again at cycles 3 and 10 during the first op -> both ignored; a single mul_done; start at cycle 11 accepted with done at cycle 21.
- kill at cycle 5 mid-ITER -> busy drops at cycle 6, no mul_done, mul_output keeps the previous value. reset=0 at cycle 4 of another op -> all outputs 0 immediately.
- APPROXIMATE=1, ACCURACY=1, accuracy_level=4: MUL 10 x 0x1F -> 0xA0. accuracy_level=0 -> 0x136 (exact).
- Non-M opcode (funct7=0000000, ADD) with start=1 -> no busy, no done, mul_output unchanged. Repeat with BPC=1 -> MUL 7x(-3) done at cycle 34.
